// File: rtl/wb_arbiter_pkg.sv
// Shared constants and types for the write-back arbiter: register-file
// widths, RV32 load funct3 codes and the arbitration state encoding.
package wb_arbiter_pkg;

   // Register-file write strobe level
   localparam logic        WriteEnable = 1'b1;
   // Reset / idle value of the write-data bus
   localparam logic [31:0] ZeroWord    = 32'h0000_0000;
   // Register index width and register data width
   localparam int          RegAddrBus  = 5;
   localparam int          RegBus      = 32;
   // Number of architectural registers
   localparam int          RegNum      = 32;

   // RV32 load funct3 encodings
   localparam logic [2:0]  EXE_LB      = 3'b000;
   localparam logic [2:0]  EXE_LH      = 3'b001;
   localparam logic [2:0]  EXE_LW      = 3'b010;
   localparam logic [2:0]  EXE_LBU     = 3'b100;
   localparam logic [2:0]  EXE_LHU     = 3'b101;

   // What the registered write port is doing this cycle
   typedef enum logic [1:0] {
      WB_IDLE   = 2'd0,   // no write
      WB_ALU    = 2'd1,   // writing a MEM/WB result
      WB_LOAD   = 2'd2,   // writing a load return drained from the FIFO
      WB_FORCED = 2'd3    // load drained because the FIFO was full (ALU stalled)
   } wb_state_e;

   // Occupancy counter width: must be able to hold the value DEPTH itself
   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the pipeline / memory controller / register file and
// the write-back arbiter. The scoreboard signals (iss_valid, iss_waddr,
// busy_mask) exist only when WB_SCOREBOARD_EN is defined.
interface wb_arbiter_if #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   import wb_arbiter_pkg::*;

   localparam int CNT_W = cnt_width(DEPTH);

   logic              rdy;
   logic              alu_valid;
   logic [ADDR_W-1:0] alu_waddr;
   logic [DATA_W-1:0] alu_wdata;
   logic              stall_req;
   logic              ld_valid;
   logic              ld_ready;
   logic [ADDR_W-1:0] ld_waddr;
   logic [DATA_W-1:0] ld_rdata;
   logic [2:0]        ld_func;
   logic [1:0]        ld_off;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic [CNT_W-1:0]  fifo_count;
`ifdef WB_SCOREBOARD_EN
   logic              iss_valid;
   logic [ADDR_W-1:0] iss_waddr;
   logic [RegNum-1:0] busy_mask;
`endif

   // Pipeline / memory-controller side
   modport master (
      output rdy, alu_valid, alu_waddr, alu_wdata,
      output ld_valid, ld_waddr, ld_rdata, ld_func, ld_off,
`ifdef WB_SCOREBOARD_EN
      output iss_valid, iss_waddr,
      input  busy_mask,
`endif
      input  stall_req, ld_ready, we, waddr, wdata, fifo_count
   );

   // Arbiter side
   modport slave (
      input  rdy, alu_valid, alu_waddr, alu_wdata,
      input  ld_valid, ld_waddr, ld_rdata, ld_func, ld_off,
`ifdef WB_SCOREBOARD_EN
      input  iss_valid, iss_waddr,
      output busy_mask,
`endif
      output stall_req, ld_ready, we, waddr, wdata, fifo_count
   );

endinterface

// File: rtl/wb_fifo.sv
// Load-return FIFO: synchronous circular buffer, DEPTH a power of two.
// Pointers wrap modulo DEPTH by natural overflow; count is registered.
// The head is read asynchronously so an entry written at one edge is
// visible to the arbiter in the very next cycle. Reset: rst, active-low.
module wb_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 37
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en_i,
   input  logic [WIDTH-1:0]           wr_data_i,
   input  logic                       rd_en_i,
   output logic [WIDTH-1:0]           rd_data_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       full_o,
   output logic                       empty_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             do_wr;
   logic             do_rd;

   assign full_o    = (count_q == CNT_W'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign count_o   = count_q;
   assign rd_data_o = mem_q[rd_ptr_q];

   // Never overrun or underrun, even if a caller misbehaves
   assign do_wr = wr_en_i && (!full_o || rd_en_i);
   assign do_rd = rd_en_i && !empty_o;

   // Occupancy next state: simultaneous push and pop leaves it unchanged
   always_comb begin
      count_d = count_q;
      case ({do_wr, do_rd})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage array: data is not reset, flushing is done through the pointers
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

   // Pointer and count registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (do_rd) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: sole owner of the register-file write port. Merges
// MEM/WB results with load returns buffered in wb_fifo, performs load
// byte/halfword extraction at enqueue time and drives registered we/waddr/
// wdata. Define WB_SCOREBOARD_EN to build the per-register pending-load
// scoreboard (iss_valid, iss_waddr, busy_mask). Reset: rst, sync, active-low.
// Extraction assumes DATA_W >= 32 (RV32 load semantics).
module wb_arbiter import wb_arbiter_pkg::*; #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = RegBus,
   parameter int ADDR_W = RegAddrBus
) (
   input  logic      clk,
   input  logic      rst,
   wb_arbiter_if.slave bus
);

   localparam int CNT_W  = cnt_width(DEPTH);
   localparam int FIFO_W = ADDR_W + DATA_W;

   // ---------------------------------------------------------------
   // Load extraction (result stored in the FIFO is final write data)
   // ---------------------------------------------------------------
   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;
   logic [DATA_W-1:0] ld_ext;

   // Select the addressed byte/halfword and extend it per funct3
   always_comb begin
      ld_byte = 8'h00;
      case (bus.ld_off)
         2'd0:    ld_byte = bus.ld_rdata[7:0];
         2'd1:    ld_byte = bus.ld_rdata[15:8];
         2'd2:    ld_byte = bus.ld_rdata[23:16];
         default: ld_byte = bus.ld_rdata[31:24];
      endcase
      // Halfword loads ignore the low offset bit
      ld_half = bus.ld_off[1] ? bus.ld_rdata[31:16] : bus.ld_rdata[15:0];
      ld_ext  = bus.ld_rdata;
      case (bus.ld_func)
         EXE_LB:  ld_ext = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
         EXE_LBU: ld_ext = {{(DATA_W-8){1'b0}}, ld_byte};
         EXE_LH:  ld_ext = {{(DATA_W-16){ld_half[15]}}, ld_half};
         EXE_LHU: ld_ext = {{(DATA_W-16){1'b0}}, ld_half};
         default: ld_ext = bus.ld_rdata;   // LW and unused codes
      endcase
   end

   // ---------------------------------------------------------------
   // Load-return FIFO
   // ---------------------------------------------------------------
   logic              ld_accept;
   logic              fifo_push;
   logic              fifo_pop;
   logic [FIFO_W-1:0] fifo_head;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_full;
   logic              fifo_empty;
   logic              ld_ready_w;

   // ld_ready comes straight from the registered count, so it cannot
   // rise in the same cycle a full FIFO is drained
   assign ld_ready_w = (fifo_count < CNT_W'(DEPTH));
   assign ld_accept  = bus.ld_valid && ld_ready_w && bus.rdy;
   // Loads to x0 are accepted but never stored
   assign fifo_push  = ld_accept && (bus.ld_waddr != '0);

   assign {head_addr, head_data} = fifo_head;

   wb_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (FIFO_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (fifo_push),
      .wr_data_i ({bus.ld_waddr, ld_ext}),
      .rd_en_i   (fifo_pop),
      .rd_data_o (fifo_head),
      .count_o   (fifo_count),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   // ---------------------------------------------------------------
   // Arbitration FSM: state_q records which source owns the write
   // port this cycle; waddr/wdata are registered alongside it.
   // ---------------------------------------------------------------
   wb_state_e         state_q;
   wb_state_e         state_d;
   logic [ADDR_W-1:0] waddr_q;
   logic [ADDR_W-1:0] waddr_d;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] wdata_d;

   // Pick the next writer: full FIFO beats ALU, ALU beats a non-empty FIFO
   always_comb begin
      state_d  = WB_IDLE;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      fifo_pop = 1'b0;
      if (bus.rdy) begin
         if (fifo_full) begin
            state_d  = WB_FORCED;
            fifo_pop = 1'b1;
            waddr_d  = head_addr;
            wdata_d  = head_data;
         end else if (bus.alu_valid && (bus.alu_waddr != '0)) begin
            state_d  = WB_ALU;
            waddr_d  = bus.alu_waddr;
            wdata_d  = bus.alu_wdata;
         end else if (!fifo_empty) begin
            state_d  = WB_LOAD;
            fifo_pop = 1'b1;
            waddr_d  = head_addr;
            wdata_d  = head_data;
         end
      end
   end

   // State and write-port registers; data holds while no write is selected
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= WB_IDLE;
         waddr_q <= '0;
         wdata_q <= DATA_W'(ZeroWord);
      end else begin
         state_q <= state_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

   assign bus.we         = (state_q != WB_IDLE) ? WriteEnable : ~WriteEnable;
   assign bus.waddr      = waddr_q;
   assign bus.wdata      = wdata_q;
   // The stall depends only on the stored count, independent of rdy
   assign bus.stall_req  = fifo_full;
   assign bus.ld_ready   = ld_ready_w;
   assign bus.fifo_count = fifo_count;

`ifdef WB_SCOREBOARD_EN
   // ---------------------------------------------------------------
   // Pending-load scoreboard. A bit clears at the same edge that loads
   // the load write into we, so busy drops in the cycle we fires. A new
   // issue to the same register in that cycle wins over the clear.
   // ---------------------------------------------------------------
   logic [RegNum-1:0] busy_q;
   logic [RegNum-1:0] busy_d;

   // x0 is never pending
   assign busy_d[0] = 1'b0;

   genvar gi;
   for (gi = 1; gi < RegNum; gi++) begin : g_busy
      logic set_w;
      logic clr_w;
      assign set_w     = bus.rdy && bus.iss_valid && (bus.iss_waddr == ADDR_W'(gi));
      assign clr_w     = fifo_pop && (head_addr == ADDR_W'(gi));
      assign busy_d[gi] = set_w || (busy_q[gi] && !clr_w);
   end

   // Scoreboard register
   always_ff @(posedge clk) begin
      if (!rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign bus.busy_mask = busy_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: table of per-cycle stimulus with expected
// registered outputs after the following clock edge, then hand-written
// sequences for mid-operation reset and (when built) the scoreboard.
module tb_wb_arbiter;
   import wb_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wb_arbiter_if #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) bus ();

   wb_arbiter #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic        rdy;
      logic        av;
      logic [4:0]  aa;
      logic [31:0] ad;
      logic        lv;
      logic [4:0]  la;
      logic [31:0] lr;
      logic [2:0]  lf;
      logic [1:0]  lo;
      logic        e_we;
      logic [4:0]  e_wa;
      logic [31:0] e_wd;
      logic [2:0]  e_cnt;
      logic        e_stall;
      logic        e_lrdy;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(
      input logic rdy, input logic av, input logic [4:0] aa, input logic [31:0] ad,
      input logic lv, input logic [4:0] la, input logic [31:0] lr, input logic [2:0] lf,
      input logic [1:0] lo, input logic e_we, input logic [4:0] e_wa, input logic [31:0] e_wd,
      input logic [2:0] e_cnt, input logic e_stall, input logic e_lrdy);
      vec_t v;
      v.rdy = rdy; v.av = av; v.aa = aa; v.ad = ad;
      v.lv = lv; v.la = la; v.lr = lr; v.lf = lf; v.lo = lo;
      v.e_we = e_we; v.e_wa = e_wa; v.e_wd = e_wd;
      v.e_cnt = e_cnt; v.e_stall = e_stall; v.e_lrdy = e_lrdy;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.rdy       = v.rdy;
      bus.alu_valid = v.av;
      bus.alu_waddr = v.aa;
      bus.alu_wdata = v.ad;
      bus.ld_valid  = v.lv;
      bus.ld_waddr  = v.la;
      bus.ld_rdata  = v.lr;
      bus.ld_func   = v.lf;
      bus.ld_off    = v.lo;
   endtask

   task automatic idle();
      drive(mk(1, 0,0,0, 0,0,0,EXE_LW,0, 0,0,0,0,0,0));
`ifdef WB_SCOREBOARD_EN
      bus.iss_valid = 1'b0;
      bus.iss_waddr = '0;
`endif
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      rst = 1'b0;
      step();
      step();
      // Reset state
      chk("rst.we",       32'(bus.we),         32'd0);
      chk("rst.waddr",    32'(bus.waddr),      32'd0);
      chk("rst.wdata",    bus.wdata,           32'd0);
      chk("rst.count",    32'(bus.fifo_count), 32'd0);
      chk("rst.stall",    32'(bus.stall_req),  32'd0);
      chk("rst.ld_ready", 32'(bus.ld_ready),   32'd1);
`ifdef WB_SCOREBOARD_EN
      chk("rst.busy",     bus.busy_mask,       32'd0);
`endif
      rst = 1'b1;

      //          rdy  alu v/a/d            ld v/a/rdata/func/off              exp we/wa/wd/cnt/stall/ldrdy
      vecs.push_back(mk(1, 1,5,32'h1234,    0,0,0,EXE_LW,0,                    1,5,32'h1234,0,0,1));
      vecs.push_back(mk(1, 1,0,32'hDEAD,    0,0,0,EXE_LW,0,                    0,5,32'h1234,0,0,1));
      vecs.push_back(mk(1, 0,0,0,           0,0,0,EXE_LW,0,                    0,5,32'h1234,0,0,1));
      vecs.push_back(mk(1, 0,0,0,           1,7,32'h80FF_0000,EXE_LB,3,        0,5,32'h1234,1,0,1));
      vecs.push_back(mk(1, 0,0,0,           0,0,0,EXE_LW,0,                    1,7,32'hFFFF_FF80,0,0,1));
      vecs.push_back(mk(1, 0,0,0,           1,8,32'h80FF_0000,EXE_LHU,2,       0,7,32'hFFFF_FF80,1,0,1));
      vecs.push_back(mk(1, 0,0,0,           1,9,32'h80FF_0000,EXE_LW,0,        1,8,32'h0000_80FF,1,0,1));
      vecs.push_back(mk(1, 0,0,0,           0,0,0,EXE_LW,0,                    1,9,32'h80FF_0000,0,0,1));
      vecs.push_back(mk(1, 1,3,32'h33,      1,4,32'h1234_8001,EXE_LH,1,        1,3,32'h33,1,0,1));
      vecs.push_back(mk(1, 0,0,0,           0,0,0,EXE_LW,0,                    1,4,32'hFFFF_8001,0,0,1));
      vecs.push_back(mk(1, 0,0,0,           1,10,32'h0000_F500,EXE_LBU,1,      0,4,32'hFFFF_8001,1,0,1));
      vecs.push_back(mk(0, 1,6,32'h66,      1,11,32'h11,EXE_LW,0,              0,4,32'hFFFF_8001,1,0,1));
      vecs.push_back(mk(0, 0,0,0,           0,0,0,EXE_LW,0,                    0,4,32'hFFFF_8001,1,0,1));
      vecs.push_back(mk(1, 1,0,32'h77,      0,0,0,EXE_LW,0,                    1,10,32'hF5,0,0,1));
      vecs.push_back(mk(1, 0,0,0,           1,0,32'hBAD,EXE_LW,0,              0,10,32'hF5,0,0,1));
      vecs.push_back(mk(1, 0,0,0,           1,12,32'hCAFE_BABE,3'b011,2,       0,10,32'hF5,1,0,1));
      vecs.push_back(mk(1, 0,0,0,           1,13,32'h0000_7F00,EXE_LB,1,       1,12,32'hCAFE_BABE,1,0,1));
      vecs.push_back(mk(1, 0,0,0,           1,14,32'hFFFE_0000,EXE_LH,3,       1,13,32'h7F,1,0,1));
      vecs.push_back(mk(1, 0,0,0,           0,0,0,EXE_LW,0,                    1,14,32'hFFFF_FFFE,0,0,1));
      vecs.push_back(mk(1, 0,0,0,           0,0,0,EXE_LW,0,                    0,14,32'hFFFF_FFFE,0,0,1));
      // Fill to full with the ALU held: one stall cycle, head drains first
      vecs.push_back(mk(1, 1,1,32'hA1,      1,16,32'h10,EXE_LW,0,              1,1,32'hA1,1,0,1));
      vecs.push_back(mk(1, 1,1,32'hA1,      1,17,32'h11,EXE_LW,0,              1,1,32'hA1,2,0,1));
      vecs.push_back(mk(1, 1,1,32'hA1,      1,18,32'h12,EXE_LW,0,              1,1,32'hA1,3,0,1));
      vecs.push_back(mk(1, 1,1,32'hA1,      1,19,32'h13,EXE_LW,0,              1,1,32'hA1,4,1,0));
      vecs.push_back(mk(1, 1,1,32'hA1,      1,20,32'h14,EXE_LW,0,              1,16,32'h10,3,0,1));
      vecs.push_back(mk(1, 1,1,32'hA1,      0,0,0,EXE_LW,0,                    1,1,32'hA1,3,0,1));
      vecs.push_back(mk(1, 0,0,0,           0,0,0,EXE_LW,0,                    1,17,32'h11,2,0,1));
      vecs.push_back(mk(1, 0,0,0,           0,0,0,EXE_LW,0,                    1,18,32'h12,1,0,1));
      vecs.push_back(mk(1, 0,0,0,           0,0,0,EXE_LW,0,                    1,19,32'h13,0,0,1));
      vecs.push_back(mk(1, 0,0,0,           0,0,0,EXE_LW,0,                    0,19,32'h13,0,0,1));
      // Full again, then rdy low: everything holds, stall stays asserted
      vecs.push_back(mk(1, 1,2,32'hB2,      1,21,32'h21,EXE_LW,0,              1,2,32'hB2,1,0,1));
      vecs.push_back(mk(1, 1,2,32'hB2,      1,22,32'h22,EXE_LW,0,              1,2,32'hB2,2,0,1));
      vecs.push_back(mk(1, 1,2,32'hB2,      1,23,32'h23,EXE_LW,0,              1,2,32'hB2,3,0,1));
      vecs.push_back(mk(1, 1,2,32'hB2,      1,24,32'h24,EXE_LW,0,              1,2,32'hB2,4,1,0));
      vecs.push_back(mk(0, 1,2,32'hB2,      1,25,32'h25,EXE_LW,0,              0,2,32'hB2,4,1,0));
      vecs.push_back(mk(1, 1,2,32'hB2,      0,0,0,EXE_LW,0,                    1,21,32'h21,3,0,1));
      vecs.push_back(mk(1, 1,2,32'hB2,      0,0,0,EXE_LW,0,                    1,2,32'hB2,3,0,1));

      foreach (vecs[i]) begin
         drive(vecs[i]);
         step();
         $display("vec %0d: we=%0b waddr=%0d wdata=0x%08h count=%0d stall=%0b ld_ready=%0b",
                  i, bus.we, bus.waddr, bus.wdata, bus.fifo_count, bus.stall_req, bus.ld_ready);
         chk($sformatf("vec%0d.we", i),       32'(bus.we),         32'(vecs[i].e_we));
         chk($sformatf("vec%0d.waddr", i),    32'(bus.waddr),      32'(vecs[i].e_wa));
         chk($sformatf("vec%0d.wdata", i),    bus.wdata,           vecs[i].e_wd);
         chk($sformatf("vec%0d.count", i),    32'(bus.fifo_count), 32'(vecs[i].e_cnt));
         chk($sformatf("vec%0d.stall", i),    32'(bus.stall_req),  32'(vecs[i].e_stall));
         chk($sformatf("vec%0d.ld_ready", i), 32'(bus.ld_ready),   32'(vecs[i].e_lrdy));
      end

      // Reset with three loads queued and live traffic on the inputs
      drive(mk(1, 1,5,32'h55, 1,26,32'h26,EXE_LW,0, 0,0,0,0,0,0));
      rst = 1'b0;
      step();
      $display("midrst: we=%0b waddr=%0d wdata=0x%08h count=%0d", bus.we, bus.waddr, bus.wdata, bus.fifo_count);
      chk("midrst.count",    32'(bus.fifo_count), 32'd0);
      chk("midrst.we",       32'(bus.we),         32'd0);
      chk("midrst.waddr",    32'(bus.waddr),      32'd0);
      chk("midrst.wdata",    bus.wdata,           32'd0);
      chk("midrst.stall",    32'(bus.stall_req),  32'd0);
      chk("midrst.ld_ready", 32'(bus.ld_ready),   32'd1);
`ifdef WB_SCOREBOARD_EN
      chk("midrst.busy",     bus.busy_mask,       32'd0);
`endif
      rst = 1'b1;
      idle();
      for (int k = 0; k < 4; k++) begin
         step();
         $display("post-rst %0d: we=%0b count=%0d", k, bus.we, bus.fifo_count);
         chk($sformatf("postrst%0d.we", k),    32'(bus.we),         32'd0);
         chk($sformatf("postrst%0d.count", k), 32'(bus.fifo_count), 32'd0);
      end

`ifdef WB_SCOREBOARD_EN
      // Issue to x9 sets bit 9
      bus.iss_valid = 1'b1; bus.iss_waddr = 5'd9;
      step();
      bus.iss_valid = 1'b0;
      $display("sb issue: busy=0x%08h", bus.busy_mask);
      chk("sb.set", bus.busy_mask, 32'h0000_0200);
      // Load return to x9: bit clears in the cycle we fires
      drive(mk(1, 0,0,0, 1,9,32'h99,EXE_LW,0, 0,0,0,0,0,0));
      step();
      chk("sb.enq_busy", bus.busy_mask, 32'h0000_0200);
      idle();
      step();
      $display("sb drain: we=%0b waddr=%0d busy=0x%08h", bus.we, bus.waddr, bus.busy_mask);
      chk("sb.clr_we",   32'(bus.we),    32'd1);
      chk("sb.clr_wa",   32'(bus.waddr), 32'd9);
      chk("sb.clr_busy", bus.busy_mask,  32'd0);
      // Reissue coinciding with the clearing drain: set wins
      bus.iss_valid = 1'b1; bus.iss_waddr = 5'd9;
      step();
      bus.iss_valid = 1'b0;
      drive(mk(1, 0,0,0, 1,9,32'h9A,EXE_LW,0, 0,0,0,0,0,0));
      step();
      idle();
      bus.iss_valid = 1'b1; bus.iss_waddr = 5'd9;
      step();
      $display("sb collide: we=%0b waddr=%0d busy=0x%08h", bus.we, bus.waddr, bus.busy_mask);
      chk("sb.col_we",   32'(bus.we),    32'd1);
      chk("sb.col_wd",   bus.wdata,      32'h9A);
      chk("sb.col_busy", bus.busy_mask,  32'h0000_0200);
      // Issue to x0 is ignored
      bus.iss_waddr = 5'd0;
      step();
      bus.iss_valid = 1'b0;
      chk("sb.x0", bus.busy_mask, 32'h0000_0200);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
